ysyx_25030085_ifu: RTL and testbench
====================================

// Module: ysyx_25030085_ifu
// PURPOSE
//  Instruction fetch unit, directly upstream of the single-cycle core top; drives its instruction input.
//  Takes the current PC from the PC unit and issues one read on a valid/ready instruction-memory bus.
//  Holds the returned word and presents it to the core until the core retires it.
//  Reports misaligned-PC, bus-error and timeout faults; supports flush of an in-flight fetch.
// PARAMETERS
//  RESET_PC        32'h8000_0000  reset value of inst_pc / latched fetch address
//  TIMEOUT_CYCLES  255            max WAIT cycles before timeout fault; 0 disables timeout
//  NOP_INST        32'h0000_0013  word driven on inst when no valid word is held (addi x0,x0,0)
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst             in   1   asynchronous, active-low reset
//  fetch_en        in   1   core may start a fetch this cycle
//  pc              in   32  fetch address from the PC unit
//  flush           in   1   discard the current or in-flight fetch
//  imem_req_valid  out  1   request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word address; always {pc[31:2],2'b00}
//  imem_resp_valid in   1   response valid
//  imem_resp_ready out  1   IFU accepts response
//  imem_resp_data  in   32  instruction word
//  imem_resp_err   in   1   bus error on this response
//  inst_valid      out  1   inst / inst_pc / fault fields valid
//  inst_ready      in   1   core retires the held instruction this cycle
//  inst            out  32  instruction to core
//  inst_pc         out  32  address the instruction was fetched from
//  inst_fault      out  1   held entry is a fault
//  fault_cause     out  2   0 none, 1 misaligned, 2 bus error, 3 timeout
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; req_valid=0, resp_ready=0, inst_valid=0, inst=NOP_INST,
//   inst_pc=RESET_PC, inst_fault=0, fault_cause=0, timer=0, orphan=0. Reset mid-transfer abandons it silently.
//  States:
//   IDLE : fetch_en & !orphan & !flush -> latch pc. If pc[1:0]!=0, go to HOLD with fault=1, cause=1;
//          no bus request. Otherwise go to REQ.
//   REQ  : req_valid=1; addr held stable until handshake. req_valid & req_ready -> WAIT, timer=0.
//          flush without handshake -> IDLE. flush with handshake in the same cycle -> DRAIN.
//   WAIT : resp_ready=1. resp_valid -> HOLD; latch data. resp_err=1 sets fault, cause=2, inst=NOP_INST.
//          flush & !resp_valid -> DRAIN. flush & resp_valid -> IDLE; response dropped.
//          Timer increments each WAIT cycle. If timer==TIMEOUT_CYCLES-1 with no response ->
//          HOLD with fault, cause=3, inst=NOP_INST, orphan=1.
//   HOLD : inst_valid=1; outputs stable. inst_ready or flush -> IDLE, inst_valid=0 next cycle.
//          flush with inst_ready in the same cycle: flush wins; both end in IDLE.
//   DRAIN: resp_ready=1; resp_valid -> IDLE, data discarded.
//  Orphan: while orphan=1, resp_ready=1 in every state and no new request is issued.
//   The first resp_valid clears orphan and is discarded.
//  inst is NOP_INST whenever inst_valid=0 or inst_fault=1.
//  Latency, zero-wait memory (req_ready=1, resp one cycle after accept):
//   fetch_en at cycle 0 -> inst_valid at cycle 3. After retire, one IDLE cycle before the next REQ,
//   so the PC unit's update has settled.
//  At most one outstanding request, never more. imem_req_addr[1:0] is always 0.
// STRUCTURE
//  Package ysyx_25030085_ifu_pkg holds: state enum (IDLE, REQ, WAIT, HOLD, DRAIN),
//   fault-cause localparams, default NOP word.
//  One sub-module, ysyx_25030085_ifu_timer: clear/enable/expire counter of width $clog2(TIMEOUT_CYCLES+1).
//   expire is tied 0 when TIMEOUT_CYCLES==0.
//  FSM, latches and orphan flag stay in the top IFU module.
// TESTING
//  1 pc=8000_0000, req_ready=1, resp one cycle later with data 0000_0513 -> inst_valid at cycle 3,
//    inst=0000_0513, inst_pc=8000_0000, fault=0.
//  2 req_ready low for 4 cycles -> req_valid and addr held stable; single handshake; exactly one request.
//  3 pc=8000_0002 -> no req_valid; HOLD with fault=1, cause=1, inst=0000_0013.
//  4 No response, TIMEOUT_CYCLES=8 -> fault cause=3 after 8 WAIT cycles. Late response with data
//    DEAD_BEEF is accepted and discarded; next fetch is issued only after it arrives.
//  5 flush asserted in WAIT -> DRAIN; the response is discarded; no inst_valid. Next fetch of
//    8000_0004 returns its own data.
//  6 Response with resp_err=1 -> cause=2, inst=NOP. Async reset (rst=0) asserted mid-WAIT ->
//    all outputs immediately at reset values.

Source files
------------

// File: rtl/ysyx_25030085_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: none (declarations only). Backpressure: not applicable.
package ysyx_25030085_ifu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } ifu_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_BUS_ERR  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25030085_ifu_timer.sv
// Response-wait counter: cleared while idle, counts while enabled, flags the last allowed cycle.
// Latency: expire is combinational from the count. Backpressure: none.
module ysyx_25030085_ifu_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = ENABLED && en_i && (cnt_q == LAST);

endmodule

// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch: one outstanding valid/ready read per PC, word held until the core retires it.
// Latency: fetch_en to inst_valid is 3 cycles on zero-wait memory; core stall holds the entry.
module ysyx_25030085_ifu
  import ysyx_25030085_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INST       = DEFAULT_NOP_INST
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  output logic        imem_resp_ready_o,
  input  logic [31:0] imem_resp_data_i,
  input  logic        imem_resp_err_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_fault_o,
  output logic [1:0]  fault_cause_o
);

  ifu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic        orphan_q, orphan_d;
  logic        expire;

  ysyx_25030085_ifu_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (state_q != S_WAIT),
    .en_i    (state_q == S_WAIT),
    .expire_o(expire)
  );

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    inst_d            = inst_q;
    fault_d           = fault_q;
    cause_d           = cause_q;
    orphan_d          = orphan_q;
    imem_req_valid_o  = 1'b0;
    // A timed-out request may still answer; keep accepting so it can be swallowed.
    imem_resp_ready_o = orphan_q;

    if (orphan_q && imem_resp_valid_i) begin
      orphan_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (fetch_en_i && !orphan_q && !flush_i) begin
          addr_d = pc_i;
          if (pc_i[1:0] != 2'b00) begin
            state_d = S_HOLD;
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
            inst_d  = NOP_INST;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        imem_req_valid_o = 1'b1;
        if (flush_i) begin
          state_d = imem_req_ready_i ? S_DRAIN : S_IDLE;
        end else if (imem_req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_resp_ready_o = 1'b1;
        if (flush_i) begin
          state_d = imem_resp_valid_i ? S_IDLE : S_DRAIN;
        end else if (imem_resp_valid_i) begin
          state_d = S_HOLD;
          fault_d = imem_resp_err_i;
          cause_d = imem_resp_err_i ? CAUSE_BUS_ERR : CAUSE_NONE;
          inst_d  = imem_resp_err_i ? NOP_INST : imem_resp_data_i;
        end else if (expire) begin
          state_d  = S_HOLD;
          fault_d  = 1'b1;
          cause_d  = CAUSE_TIMEOUT;
          inst_d   = NOP_INST;
          orphan_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (inst_ready_i || flush_i) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
          inst_d  = NOP_INST;
        end
      end
      S_DRAIN: begin
        imem_resp_ready_o = 1'b1;
        if (imem_resp_valid_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      addr_q   <= RESET_PC;
      inst_q   <= NOP_INST;
      fault_q  <= 1'b0;
      cause_q  <= CAUSE_NONE;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      fault_q  <= fault_d;
      cause_q  <= cause_d;
      orphan_q <= orphan_d;
    end
  end

  assign imem_req_addr_o = {addr_q[31:2], 2'b00};
  assign inst_valid_o    = (state_q == S_HOLD);
  assign inst_o          = (inst_valid_o && !fault_q) ? inst_q : NOP_INST;
  assign inst_pc_o       = addr_q;
  assign inst_fault_o    = fault_q;
  assign fault_cause_o   = cause_q;

endmodule

// File: tb/tb_ysyx_25030085_ifu.sv
// Directed bench for the fetch unit with a zero-wait responder that can be switched to manual drive.
module tb_ysyx_25030085_ifu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        flush = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [31:0] resp_data = 32'h0;
  logic        resp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [1:0]  fault_cause;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          req_cnt = 0;
  int          req_base = 0;
  logic        auto_resp = 1'b1;
  logic        mem_err = 1'b0;
  logic [31:0] mem_data = 32'h0;

  always #5 clk = ~clk;

  ysyx_25030085_ifu #(
    .RESET_PC      (32'h8000_0000),
    .TIMEOUT_CYCLES(8),
    .NOP_INST      (32'h0000_0013)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .fetch_en_i       (fetch_en),
    .pc_i             (pc),
    .flush_i          (flush),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_resp_valid_i(resp_valid),
    .imem_resp_ready_o(resp_ready),
    .imem_resp_data_i (resp_data),
    .imem_resp_err_i  (resp_err),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .inst_fault_o     (inst_fault),
    .fault_cause_o    (fault_cause)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; the zero-wait responder answers one cycle after each accepted request.
  task automatic step();
    logic hs;
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (hs) req_cnt++;
    if (auto_resp) begin
      resp_valid = hs;
      resp_data  = hs ? mem_data : 32'h0;
      resp_err   = hs & mem_err;
    end
  endtask

  initial begin
    #12;
    check("rst_req_valid", req_valid, 0);
    check("rst_resp_ready", resp_ready, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'h8000_0000);
    check("rst_fault", inst_fault, 0);
    check("rst_cause", fault_cause, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero-wait fetch: inst_valid three cycles after fetch_en.
    mem_data = 32'h0000_0513;
    fetch_en = 1'b1;
    pc       = 32'h8000_0000;
    check("t1_c0_valid", inst_valid, 0);
    step(); fetch_en = 1'b0;
    check("t1_c1_req_valid", req_valid, 1);
    check("t1_c1_addr", req_addr, 32'h8000_0000);
    step();
    check("t1_c2_valid", inst_valid, 0);
    check("t1_c2_resp_ready", resp_ready, 1);
    step();
    check("t1_c3_valid", inst_valid, 1);
    check("t1_inst", inst, 32'h0000_0513);
    check("t1_inst_pc", inst_pc, 32'h8000_0000);
    check("t1_fault", inst_fault, 0);
    check("t1_cause", fault_cause, 0);

    // Retire with the next fetch pending: one idle gap, then a request stalled 4 cycles.
    inst_ready = 1'b1;
    fetch_en   = 1'b1;
    pc         = 32'h8000_0004;
    req_ready  = 1'b0;
    mem_data   = 32'h0000_0593;
    req_base   = req_cnt;
    step(); inst_ready = 1'b0;
    check("t2_idle_gap_req", req_valid, 0);
    check("t2_idle_gap_valid", inst_valid, 0);
    step(); fetch_en = 1'b0; pc = 32'h8000_0100;
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_req_valid", req_valid, 1);
      check("t2_stall_addr", req_addr, 32'h8000_0004);
      if (i == 4) req_ready = 1'b1;
      step();
    end
    check("t2_after_hs_req_valid", req_valid, 0);
    step();
    check("t2_inst", inst, 32'h0000_0593);
    check("t2_inst_pc", inst_pc, 32'h8000_0004);
    check("t2_one_request", req_cnt - req_base, 1);
    inst_ready = 1'b1;
    step(); inst_ready = 1'b0;
    check("t2_retired", inst_valid, 0);

    // Misaligned PC: no bus request, fault held until flush (flush beats inst_ready).
    fetch_en = 1'b1;
    pc       = 32'h8000_0002;
    req_base = req_cnt;
    step(); fetch_en = 1'b0;
    check("t3_req_valid", req_valid, 0);
    check("t3_valid", inst_valid, 1);
    check("t3_fault", inst_fault, 1);
    check("t3_cause", fault_cause, 1);
    check("t3_inst", inst, 32'h0000_0013);
    check("t3_inst_pc", inst_pc, 32'h8000_0002);
    step();
    check("t3_held", inst_valid, 1);
    flush = 1'b1; inst_ready = 1'b1;
    step(); flush = 1'b0; inst_ready = 1'b0;
    check("t3_flushed", inst_valid, 0);
    check("t3_no_request", req_cnt - req_base, 0);

    // Timeout after 8 WAIT cycles, then an orphan response blocks the next fetch.
    auto_resp = 1'b0;
    fetch_en  = 1'b1;
    pc        = 32'h8000_0008;
    step(); fetch_en = 1'b0;
    step();
    repeat (7) step();
    check("t4_wait8_valid", inst_valid, 0);
    check("t4_wait8_resp_ready", resp_ready, 1);
    step();
    check("t4_timeout_valid", inst_valid, 1);
    check("t4_timeout_fault", inst_fault, 1);
    check("t4_timeout_cause", fault_cause, 3);
    check("t4_timeout_inst", inst, 32'h0000_0013);
    inst_ready = 1'b1;
    step(); inst_ready = 1'b0;
    fetch_en = 1'b1;
    pc       = 32'h8000_000C;
    req_base = req_cnt;
    for (int i = 0; i < 3; i++) begin
      check("t4_orphan_no_req", req_valid, 0);
      check("t4_orphan_resp_ready", resp_ready, 1);
      step();
    end
    resp_valid = 1'b1;
    resp_data  = 32'hDEAD_BEEF;
    step(); resp_valid = 1'b0; resp_data = 32'h0;
    check("t4_cleared_idle", req_valid, 0);
    check("t4_cleared_no_req", req_cnt - req_base, 0);
    auto_resp = 1'b1;
    mem_data  = 32'h0000_0613;
    step(); fetch_en = 1'b0;
    check("t4_next_req", req_valid, 1);
    check("t4_next_addr", req_addr, 32'h8000_000C);
    step();
    step();
    check("t4_next_inst", inst, 32'h0000_0613);
    check("t4_next_fault", inst_fault, 0);
    inst_ready = 1'b1;
    step(); inst_ready = 1'b0;

    // Flush in WAIT drains the response without presenting it.
    auto_resp = 1'b0;
    fetch_en  = 1'b1;
    pc        = 32'h8000_0004;
    step(); fetch_en = 1'b0;
    step();
    flush = 1'b1;
    step(); flush = 1'b0;
    check("t5_drain_resp_ready", resp_ready, 1);
    check("t5_drain_valid", inst_valid, 0);
    check("t5_drain_no_req", req_valid, 0);
    resp_valid = 1'b1;
    resp_data  = 32'h1111_1111;
    step(); resp_valid = 1'b0; resp_data = 32'h0;
    check("t5_idle_valid", inst_valid, 0);
    check("t5_idle_resp_ready", resp_ready, 0);
    auto_resp = 1'b1;
    mem_data  = 32'h0000_0713;
    fetch_en  = 1'b1;
    pc        = 32'h8000_0004;
    step(); fetch_en = 1'b0;
    step();
    step();
    check("t5_refetch_inst", inst, 32'h0000_0713);
    check("t5_refetch_pc", inst_pc, 32'h8000_0004);
    inst_ready = 1'b1;
    step(); inst_ready = 1'b0;

    // Bus error response, then asynchronous reset in the middle of WAIT.
    mem_err  = 1'b1;
    mem_data = 32'h1234_5678;
    fetch_en = 1'b1;
    pc       = 32'h8000_0010;
    step(); fetch_en = 1'b0;
    step();
    step();
    check("t6_err_valid", inst_valid, 1);
    check("t6_err_fault", inst_fault, 1);
    check("t6_err_cause", fault_cause, 2);
    check("t6_err_inst", inst, 32'h0000_0013);
    inst_ready = 1'b1;
    step(); inst_ready = 1'b0;
    mem_err   = 1'b0;
    auto_resp = 1'b0;
    fetch_en  = 1'b1;
    pc        = 32'h8000_0014;
    step(); fetch_en = 1'b0;
    step();
    check("t6_wait_resp_ready", resp_ready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_arst_resp_ready", resp_ready, 0);
    check("t6_arst_req_valid", req_valid, 0);
    check("t6_arst_inst_valid", inst_valid, 0);
    check("t6_arst_inst", inst, 32'h0000_0013);
    check("t6_arst_inst_pc", inst_pc, 32'h8000_0000);
    check("t6_arst_cause", fault_cause, 0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_post_rst_idle", req_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
